icache_mem_arbiter: RTL and testbench

- Responder end of the cache/arbiter request-wait protocol.
- Services instruction-fetch reads from the icache and read/write requests from the dcache through one shared single-port memory interface.
- Raises `iwait`/`dwait` while a request is in service and returns the load data.
- Sits between the two L1 caches and the memory/bus model.

---
 rtl/icache_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_icache_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_arbiter.sv
// icache_mem_arbiter: shares one single-port memory interface between the
// icache (read-only) and the dcache (read/write) using a request/wait handshake.
// Ties are broken round-robin. A stalled memory access can be aborted by a timeout,
// which sets a sticky error flag.
module icache_mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);
    localparam logic        TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    state_t              r_state, w_state_nxt;
    logic                r_last_d, w_last_d_nxt;   // 1: last grant went to dcache
    logic [15:0]         r_stall, w_stall_nxt;
    logic                r_iwait, w_iwait_nxt;
    logic                r_dwait, w_dwait_nxt;
    logic [WORD_W-1:0]   r_iload, w_iload_nxt;
    logic [WORD_W-1:0]   r_dload, w_dload_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [WORD_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                r_err, w_err_nxt;

    logic                w_dreq;
    logic [15:0]         w_stall_inc;
    logic                w_expired;
    logic [WORD_W-1:0]   w_rd;

    // dREN and dWEN together are treated as a write (mem_we follows dWEN)
    assign w_dreq      = dREN | dWEN;
    assign w_stall_inc = r_stall + 16'd1;
    assign w_expired   = TIMEOUT_EN && (w_stall_inc == TIMEOUT_CNT);
    // An aborted access returns zeros as its read data
    assign w_rd        = mem_ready ? mem_rdata : '0;

    // State register and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b0;
            r_stall     <= '0;
            r_iwait     <= 1'b1;
            r_dwait     <= 1'b1;
            r_iload     <= '0;
            r_dload     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_d    <= w_last_d_nxt;
            r_stall     <= w_stall_nxt;
            r_iwait     <= w_iwait_nxt;
            r_dwait     <= w_dwait_nxt;
            r_iload     <= w_iload_nxt;
            r_dload     <= w_dload_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state and next-output logic; waits are low only for the RESP cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_last_d_nxt    = r_last_d;
        w_stall_nxt     = r_stall;
        w_iwait_nxt     = 1'b1;
        w_dwait_nxt     = 1'b1;
        w_iload_nxt     = r_iload;
        w_dload_nxt     = r_dload;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_err_nxt       = r_err;
        case (r_state)
            IDLE: begin
                if (iREN || w_dreq) begin
                    // dcache wins when alone, or on a tie if icache had the last grant
                    if (w_dreq && (!iREN || !r_last_d)) begin
                        w_state_nxt     = GRANT_D;
                        w_last_d_nxt    = 1'b1;
                        w_mem_addr_nxt  = daddr;
                        w_mem_we_nxt    = dWEN;
                        w_mem_wdata_nxt = dstore;
                    end else begin
                        w_state_nxt     = GRANT_I;
                        w_last_d_nxt    = 1'b0;
                        w_mem_addr_nxt  = iaddr;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_wdata_nxt = '0;
                    end
                    w_mem_req_nxt = 1'b1;
                    w_stall_nxt   = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready || w_expired) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = RESP;
                    if (!mem_ready)
                        w_err_nxt = 1'b1;
                    if (r_state == GRANT_I) begin
                        w_iwait_nxt = 1'b0;
                        w_iload_nxt = w_rd;
                    end else begin
                        w_dwait_nxt = 1'b0;
                        if (!r_mem_we)
                            w_dload_nxt = w_rd;
                    end
                end else begin
                    w_stall_nxt = w_stall_inc;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign iwait     = r_iwait;
    assign dwait     = r_dwait;
    assign iload     = r_iload;
    assign dload     = r_dload;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Testbench for icache_mem_arbiter: directed requests against a transaction-level
// reference model, a per-cycle compare process and hand-computed literal checks.
module tb_icache_mem_arbiter;

    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    icache_mem_arbiter #(.WORD_W(32), .ADDR_W(32), .MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder: answers mem_lat cycles after it first sees mem_req
    int          mem_lat = 0;
    int          mem_cnt = 0;
    bit          mem_fixed = 0;
    logic [31:0] mem_fixed_val = '0;
    bit          stray = 0;
    always @(negedge CLK) begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (mem_req) begin
            if (mem_cnt == mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_fixed ? mem_fixed_val : (mem_addr ^ 32'h5A5A_0000);
            end
            mem_cnt++;
        end else begin
            mem_cnt = 0;
            if (stray) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Reference model: one outstanding transaction, tracked as idle/busy/responding
    typedef enum {P_IDLE, P_BUSY, P_RESP} ph_t;
    ph_t         ph;
    bit          own_d, last_d, expired;
    int          stalls;
    logic [31:0] rd;
    logic        e_iwait, e_dwait, e_mem_req, e_mem_we, e_err;
    logic [31:0] e_iload, e_dload, e_mem_addr, e_mem_wdata;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ph = P_IDLE; own_d = 0; last_d = 0; stalls = 0;
            e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_err = 0;
        end else begin
            e_iwait = 1;
            e_dwait = 1;
            if (ph == P_RESP) begin
                ph = P_IDLE;
            end else if (ph == P_IDLE) begin
                if (iREN || dREN || dWEN) begin
                    own_d       = (dREN || dWEN) && !(iREN && last_d);
                    last_d      = own_d;
                    e_mem_req   = 1;
                    e_mem_addr  = own_d ? daddr : iaddr;
                    e_mem_we    = own_d && dWEN;
                    e_mem_wdata = dstore;
                    stalls      = 0;
                    ph          = P_BUSY;
                end
            end else begin
                expired = (TO != 0) && (stalls + 1 >= TO);
                if (mem_ready || expired) begin
                    e_mem_req = 0;
                    ph        = P_RESP;
                    if (!mem_ready) e_err = 1;
                    rd = mem_ready ? mem_rdata : 32'h0;
                    if (own_d) begin
                        e_dwait = 0;
                        if (!e_mem_we) e_dload = rd;
                    end else begin
                        e_iwait = 0;
                        e_iload = rd;
                    end
                end else begin
                    stalls++;
                end
            end
        end
    end

    // Compare process: DUT against model every cycle, away from the active edge
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_iwait", 32'(iwait), 32'(e_iwait));
            chk("m_dwait", 32'(dwait), 32'(e_dwait));
            chk("m_iload", iload, e_iload);
            chk("m_dload", dload, e_dload);
            chk("m_mem_req", 32'(mem_req), 32'(e_mem_req));
            chk("m_err", 32'(err), 32'(e_err));
            if (e_mem_req) begin
                chk("m_mem_addr", mem_addr, e_mem_addr);
                chk("m_mem_we", 32'(mem_we), 32'(e_mem_we));
                if (e_mem_we) chk("m_mem_wdata", mem_wdata, e_mem_wdata);
            end
        end
    end

    // Grant log: address of every memory request, in order of issue
    logic [31:0] glog[$];
    logic        prev_req = 1'b0;
    always @(negedge CLK) begin
        if (mem_req && !prev_req) glog.push_back(mem_addr);
        prev_req = mem_req;
    end

    // Wait for completion of the request the caller just raised; drop it on wait=0
    task automatic run_txn(input string nm, input bit is_d,
                           output int mreq_at, output int done_at, output int req_cyc);
        mreq_at = -1; done_at = -1; req_cyc = 0;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge CLK);
            if (mem_req) begin
                req_cyc++;
                if (mreq_at < 0) mreq_at = k;
            end
            if ((is_d ? dwait : iwait) == 1'b0) begin
                done_at = k;
                if (is_d) begin dREN = 0; dWEN = 0; end
                else iREN = 0;
            end
        end
        if (done_at < 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no wait=0 within 40 cycles", nm);
            iREN = 0; dREN = 0; dWEN = 0;
        end else begin
            @(negedge CLK);
            chk({nm, "_wait_one_cycle"}, 32'(is_d ? dwait : iwait), 32'd1);
        end
    endtask

    int ma, da, rc;

    initial begin
        #1 nRST = 1'b0;
        #1 cmp_en = 1;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Idle after reset
        repeat (5) begin
            @(negedge CLK);
            chk("idle_iwait", 32'(iwait), 32'd1);
            chk("idle_dwait", 32'(dwait), 32'd1);
            chk("idle_mem_req", 32'(mem_req), 32'd0);
            chk("idle_err", 32'(err), 32'd0);
        end

        // icache read, memory answers 3 cycles after mem_req
        mem_lat = 3; mem_fixed = 1; mem_fixed_val = 32'hDEAD_BEEF;
        @(negedge CLK);
        iREN = 1; iaddr = 32'h0000_0040;
        run_txn("iread", 0, ma, da, rc);
        chk("iread_mreq_at", 32'(ma), 32'd1);
        chk("iread_done_at", 32'(da), 32'd5);
        chk("iread_req_cycles", 32'(rc), 32'd4);
        chk("iread_mem_addr", mem_addr, 32'h40);
        chk("iread_mem_we", 32'(mem_we), 32'd0);
        chk("iread_iload", iload, 32'hDEAD_BEEF);

        // Tie with both held: dcache first (icache had last grant), then alternate
        mem_lat = 0; mem_fixed = 0;
        glog.delete();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
        repeat (11) @(negedge CLK);
        iREN = 0; dREN = 0;
        repeat (3) @(negedge CLK);
        chk("tie_grant_count", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            chk("tie_grant0", glog[0], 32'h300);
            chk("tie_grant1", glog[1], 32'h200);
            chk("tie_grant2", glog[2], 32'h300);
            chk("tie_grant3", glog[3], 32'h200);
        end
        chk("tie_dload", dload, 32'h5A5A_0300);
        chk("tie_iload", iload, 32'h5A5A_0200);

        // dcache read, zero-wait memory
        mem_fixed = 1; mem_fixed_val = 32'hCAFE_F00D;
        @(negedge CLK);
        dREN = 1; daddr = 32'h80;
        run_txn("dread", 1, ma, da, rc);
        chk("dread_done_at", 32'(da), 32'd2);
        chk("dread_dload", dload, 32'hCAFE_F00D);

        // dcache write, zero-wait memory: dload untouched
        @(negedge CLK);
        dWEN = 1; daddr = 32'h100; dstore = 32'h1234_5678;
        run_txn("dwrite", 1, ma, da, rc);
        chk("dwrite_mreq_at", 32'(ma), 32'd1);
        chk("dwrite_done_at", 32'(da), 32'd2);
        chk("dwrite_mem_we", 32'(mem_we), 32'd1);
        chk("dwrite_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("dwrite_mem_addr", mem_addr, 32'h100);
        chk("dwrite_dload", dload, 32'hCAFE_F00D);

        // dREN and dWEN together act as a write
        @(negedge CLK);
        dREN = 1; dWEN = 1; daddr = 32'h104; dstore = 32'h0000_55AA;
        run_txn("drw", 1, ma, da, rc);
        chk("drw_mem_we", 32'(mem_we), 32'd1);
        chk("drw_dload", dload, 32'hCAFE_F00D);

        // Stray mem_ready while idle is ignored
        stray = 1;
        repeat (3) @(negedge CLK);
        stray = 0;
        @(negedge CLK);
        chk("stray_dload", dload, 32'hCAFE_F00D);
        chk("stray_state", 32'({iwait, dwait, mem_req}), 32'b110);

        // dcache read that never completes: timeout after TO stall cycles
        mem_lat = 1000;
        @(negedge CLK);
        dREN = 1; daddr = 32'h400;
        run_txn("tmo", 1, ma, da, rc);
        chk("tmo_req_cycles", 32'(rc), 32'd8);
        chk("tmo_done_at", 32'(da), 32'd9);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_dload", dload, 32'h0);

        // Reset in the middle of an icache grant
        @(negedge CLK);
        iREN = 1; iaddr = 32'h500;
        repeat (2) @(negedge CLK);
        chk("rst_pre_mem_req", 32'(mem_req), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        iREN = 0;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            chk("rst_no_resp_iwait", 32'(iwait), 32'd1);
            chk("rst_no_resp_mem_req", 32'(mem_req), 32'd0);
        end

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
